// File: rtl/pipo_bank.sv
// pipo_bank: captures switch snapshots into a circular bank on button presses,
// steps through stored snapshots, and drives either live switches or the
// selected snapshot onto the LEDs.
module pipo_bank #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       btn,
    output logic [WIDTH-1:0] led,
    output logic [PW-1:0]    slot,
    output logic [PW:0]      count,
    output logic             full
);

    localparam int unsigned BTN_LOAD  = 0;
    localparam int unsigned BTN_VIEW  = 1;
    localparam int unsigned BTN_NEXT  = 2;
    localparam int unsigned BTN_CLEAR = 3;

    // Button synchroniser and edge-detect history
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       btn_s_q, btn_s_d;
    logic [3:0]       btn_prev_q, btn_prev_d;

    // Bank control state
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    slot_q, slot_d;
    logic [PW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] led_q, led_d;

    // Snapshot storage, intentionally not reset
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic             bank_we;

    logic [3:0]       edge_ev;
    logic             ev_clear, ev_load, ev_next;
    logic             view;
    logic [PW-1:0]    oldest;
    logic             unused_view_prev;

    // Rising-edge events with clear > load > next priority; lower ones are dropped
    always_comb begin
        edge_ev          = btn_s_q & ~btn_prev_q;
        ev_clear         = edge_ev[BTN_CLEAR];
        ev_load          = edge_ev[BTN_LOAD] & ~ev_clear;
        ev_next          = edge_ev[BTN_NEXT] & ~edge_ev[BTN_LOAD] & ~ev_clear;
        view             = btn_s_q[BTN_VIEW];
        unused_view_prev = btn_prev_q[BTN_VIEW];
    end

    // Next-state logic for synchroniser, pointers, count and LED mux
    always_comb begin
        sync1_d    = btn;
        btn_s_d    = sync1_q;
        btn_prev_d = btn_s_q;
        wr_ptr_d   = wr_ptr_q;
        slot_d     = slot_q;
        count_d    = count_q;
        bank_we    = 1'b0;
        oldest     = wr_ptr_q - PW'(count_q);

        // LED reflects the selection as it stood before this edge's event
        if (!view) begin
            led_d = sw;
        end else if (count_q != '0) begin
            led_d = bank_q[slot_q];
        end else begin
            led_d = '0;
        end

        if (ev_clear) begin
            wr_ptr_d = '0;
            slot_d   = '0;
            count_d  = '0;
        end else if (ev_load) begin
            bank_we  = 1'b1;
            slot_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q != (PW+1)'(DEPTH)) begin
                count_d = count_q + (PW+1)'(1);
            end
        end else if (ev_next && (count_q != '0)) begin
            // Step to next older entry, wrapping from oldest back to newest
            if (slot_q == oldest) begin
                slot_d = wr_ptr_q - PW'(1);
            end else begin
                slot_d = slot_q - PW'(1);
            end
        end

        full_d = (count_d == (PW+1)'(DEPTH));
    end

    // State registers with synchronous reset; buttons reset high to mask held presses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            btn_s_q    <= '1;
            btn_prev_q <= '1;
            wr_ptr_q   <= '0;
            slot_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            led_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            btn_s_q    <= btn_s_d;
            btn_prev_q <= btn_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            slot_q     <= slot_d;
            count_q    <= count_d;
            full_q     <= full_d;
            led_q      <= led_d;
        end
    end

    // Single write port into the snapshot bank
    always_ff @(posedge clk) begin
        if (!rst && bank_we) begin
            bank_q[wr_ptr_q] <= sw;
        end
    end

    assign led   = led_q;
    assign slot  = slot_q;
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: tb/tb_pipo_bank.sv
// Self-checking bench for pipo_bank: directed steps plus random button/switch
// activity compared against a queue-based model of the snapshot history.
module tb_pipo_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic [3:0]       btn;
    logic [WIDTH-1:0] led;
    logic [PW-1:0]    slot;
    logic [PW:0]      count;
    logic             full;

    pipo_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .btn   (btn),
        .led   (led),
        .slot  (slot),
        .count (count),
        .full  (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: snapshots oldest..newest, selected index into that list, loads since clear
    logic [WIDTH-1:0] snaps[$];
    int               sel;
    int               nload;
    logic             view_on;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_led();
        if (!view_on) return sw;
        if (snaps.size() == 0) return '0;
        return snaps[sel];
    endfunction

    function automatic int exp_slot();
        if (snaps.size() == 0) return 0;
        return (nload - snaps.size() + sel) % DEPTH;
    endfunction

    function automatic void apply_event(input logic [3:0] mask);
        if (mask[3]) begin
            snaps.delete();
            sel   = 0;
            nload = 0;
        end else if (mask[0]) begin
            snaps.push_back(sw);
            if (snaps.size() > DEPTH) void'(snaps.pop_front());
            sel = snaps.size() - 1;
            nload++;
        end else if (mask[2] && snaps.size() > 0) begin
            sel = (sel == 0) ? snaps.size() - 1 : sel - 1;
        end
    endfunction

    task automatic drive(input logic [3:0] mask);
        btn = mask | (view_on ? 4'b0010 : 4'b0000);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(snaps.size()));
        chk({tag, "_slot"},  32'(slot),  32'(exp_slot()));
        chk({tag, "_full"},  32'(full),  32'(snaps.size() == DEPTH));
        chk({tag, "_led"},   32'(led),   32'(exp_led()));
    endtask

    // One press: nothing changes before the 3rd edge, state updates on it,
    // LED shows the new selection one edge later
    task automatic press(input logic [3:0] mask, input int hold, input string tag);
        logic [WIDTH-1:0] pre_led;
        pre_led = exp_led();
        drive(mask);
        tick();
        tick();
        chk({tag, "_early_count"}, 32'(count), 32'(snaps.size()));
        tick();
        apply_event(mask);
        chk({tag, "_act_count"}, 32'(count), 32'(snaps.size()));
        chk({tag, "_act_slot"},  32'(slot),  32'(exp_slot()));
        chk({tag, "_act_full"},  32'(full),  32'(snaps.size() == DEPTH));
        chk({tag, "_act_led"},   32'(led),   32'(pre_led));
        tick();
        chk({tag, "_post_led"},  32'(led),   32'(exp_led()));
        repeat (hold) tick();
        drive(4'b0000);
        repeat (3) tick();
        chk_all({tag, "_rel"});
    endtask

    task automatic set_view(input logic v);
        view_on = v;
        drive(4'b0000);
        repeat (3) tick();
        chk_all("view");
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        sw      = 8'h5A;
        btn     = 4'b0001;
        view_on = 1'b0;
        sel     = 0;
        nload   = 0;

        // Reset with load held: registers cleared, no event on release
        repeat (3) tick();
        chk("rst_led",   32'(led),   32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_slot",  32'(slot),  32'h0);
        chk("rst_full",  32'(full),  32'h0);
        sw  = 8'h00;
        rst = 1'b0;
        repeat (5) tick();
        chk("held_count", 32'(count), 32'h0);
        chk("held_led",   32'(led),   32'h0);
        drive(4'b0000);
        repeat (3) tick();
        press(4'b0001, 1, "first_load");

        // Live switches with view off
        sw = 8'hA5;
        tick();
        chk("live_a5", 32'(led), 32'hA5);
        sw = 8'h3C;
        tick();
        chk("live_3c", 32'(led), 32'h3C);

        // Three loads, then view and step back with wrap to newest
        press(4'b1000, 1, "clr1");
        sw = 8'h11; press(4'b0001, 1, "ld11");
        sw = 8'h22; press(4'b0001, 1, "ld22");
        sw = 8'h33; press(4'b0001, 1, "ld33");
        set_view(1'b1);
        chk("three_led", 32'(led), 32'h33);
        chk("three_slot", 32'(slot), 32'h2);
        repeat (3) press(4'b0100, 1, "next3");

        // Overfill: oldest entry overwritten
        press(4'b1000, 1, "clr2");
        for (int i = 1; i <= 5; i++) begin
            sw = 8'(i);
            press(4'b0001, 1, "fill");
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_led", 32'(led), 32'h05);
        repeat (4) press(4'b0100, 1, "next4");

        // Long hold gives exactly one load; clear beats load
        sw = 8'h77;
        press(4'b0001, 20, "hold20");
        press(4'b1001, 1, "clr_ld");
        chk("clr_ld_led", 32'(led), 32'h0);

        // Empty bank: next does nothing, load appears on the following edge
        press(4'b0100, 1, "next_empty");
        sw = 8'hFF;
        press(4'b0001, 1, "ld_ff");
        chk("ld_ff_led", 32'(led), 32'hFF);

        // Random activity against the model
        for (int it = 0; it < 60; it++) begin
            int r;
            logic [3:0] m;
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                sw = 8'($urandom);
                tick();
                chk("rnd_sw", 32'(led), 32'(exp_led()));
            end else if (r == 2) begin
                set_view(~view_on);
            end else if (r <= 5) begin
                sw = 8'($urandom);
                press(4'b0001, $urandom_range(0, 3), "rnd_ld");
            end else if (r <= 7) begin
                press(4'b0100, $urandom_range(0, 3), "rnd_nx");
            end else if (r == 8) begin
                press(4'b1000, 0, "rnd_clr");
            end else begin
                m = 4'($urandom) & 4'b1101;
                if (m == 4'b0000) m = 4'b0101;
                sw = 8'($urandom);
                press(m, 1, "rnd_mix");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
